// File: rtl/mmap_synth_regs.sv
`timescale 1ns/1ps
// mmap_synth_regs
// Memory-mapped control block for the multi-voice synthesizer. Decodes CPU
// loads/stores in the I/O window and holds the global and per-voice synth
// registers. It also generates one-cycle note control pulses, keeps sticky
// per-voice finished flags, and runs the cycle/instruction counters. The PWM
// duty request/acknowledge handshake runs on its own once a duty value is stored.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   en/addr/sel    access strobe, word address, op (1=LOAD, 2=STORE, 6=nop)
//   wdata/rdata    store data in, registered load data out
//   fcw            per-voice frequency control words, voice v at [v*FCW_WIDTH +: FCW_WIDTH]
//   note_start/note_release/note_reset  one-cycle per-voice pulses
//   note_finished  one-cycle finished pulses from the voices
//   *_shift, global_gain  NCO waveform shifts and output gain shift
//   dac_source     0 = CPU duty, 1 = synth
//   duty_cycle, tx_req, tx_ack  duty handshake towards pwm_controller
module mmap_synth_regs #(
    parameter int NUM_VOICES  = 4,
    parameter int FCW_WIDTH   = 24,
    parameter int SHIFT_WIDTH = 5,
    parameter int DUTY_WIDTH  = 12
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [15:0]                     addr,
    input  logic [2:0]                      sel,
    input  logic [31:0]                     wdata,
    output logic [31:0]                     rdata,
    output logic [NUM_VOICES*FCW_WIDTH-1:0] fcw,
    output logic [NUM_VOICES-1:0]           note_start,
    output logic [NUM_VOICES-1:0]           note_release,
    output logic [NUM_VOICES-1:0]           note_reset,
    input  logic [NUM_VOICES-1:0]           note_finished,
    output logic [SHIFT_WIDTH-1:0]          sine_shift,
    output logic [SHIFT_WIDTH-1:0]          square_shift,
    output logic [SHIFT_WIDTH-1:0]          triangle_shift,
    output logic [SHIFT_WIDTH-1:0]          sawtooth_shift,
    output logic [SHIFT_WIDTH-1:0]          global_gain,
    output logic                            dac_source,
    output logic [DUTY_WIDTH-1:0]           duty_cycle,
    output logic                            tx_req,
    input  logic                            tx_ack
);

    localparam logic [2:0]  SEL_LOAD    = 3'd1;
    localparam logic [2:0]  SEL_STORE   = 3'd2;
    localparam logic [2:0]  SEL_NOP     = 3'd6;

    localparam logic [15:0] ADDR_CYCLE  = 16'h0010;
    localparam logic [15:0] ADDR_INSTR  = 16'h0014;
    localparam logic [15:0] ADDR_CNTRST = 16'h0018;
    localparam logic [15:0] ADDR_DUTY   = 16'h0034;
    localparam logic [15:0] ADDR_STATUS = 16'h0040;
    localparam logic [15:0] ADDR_DACSRC = 16'h0044;
    localparam logic [15:0] ADDR_GRST   = 16'h0100;
    localparam logic [15:0] ADDR_GAIN   = 16'h0104;

    localparam logic [4:0]  OFF_FCW     = 5'h00;
    localparam logic [4:0]  OFF_START   = 5'h04;
    localparam logic [4:0]  OFF_RELEASE = 5'h08;
    localparam logic [4:0]  OFF_FINISH  = 5'h0C;
    localparam logic [4:0]  OFF_RESET   = 5'h10;

    typedef enum logic [1:0] {
        PWM_IDLE = 2'd0,
        PWM_REQ  = 2'd1,
        PWM_DROP = 2'd2
    } pwm_state_t;

    // ---------------- decode ----------------
    logic       is_load, is_store;
    logic       voice_win, voice_valid;
    logic [2:0] voice_idx;
    logic [4:0] voice_off;
    logic       shift_hit;
    logic [1:0] shift_sel;
    logic       st_cnt_rst, st_duty, st_glob_rst;
    logic       unused_wdata;

    assign is_load     = en && (sel == SEL_LOAD);
    assign is_store    = en && (sel == SEL_STORE);
    // Voice window 0x1000-0x10FF: eight 32-byte slots, only the first NUM_VOICES are real.
    assign voice_win   = (addr[15:8] == 8'h10);
    assign voice_idx   = addr[7:5];
    assign voice_off   = addr[4:0];
    assign voice_valid = voice_win && (int'(voice_idx) < NUM_VOICES);
    // Shift registers live at 0x0200/04/08/0C.
    assign shift_hit   = (addr[15:4] == 12'h020) && (addr[1:0] == 2'b00);
    assign shift_sel   = addr[3:2];
    assign st_cnt_rst  = is_store && (addr == ADDR_CNTRST);
    assign st_duty     = is_store && (addr == ADDR_DUTY);
    assign st_glob_rst = is_store && (addr == ADDR_GRST);
    // High store-data bits beyond each register's width are deliberately dropped.
    assign unused_wdata = ^wdata;

    // ---------------- global registers and counters ----------------
    logic                   dac_source_reg;
    logic [SHIFT_WIDTH-1:0] gain_reg;
    logic [SHIFT_WIDTH-1:0] shift_reg [4];
    logic [31:0]            cycle_count_reg, instr_count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dac_source_reg  <= 1'b0;
            gain_reg        <= '0;
            cycle_count_reg <= '0;
            instr_count_reg <= '0;
        end else begin
            if (is_store && addr == ADDR_DACSRC) dac_source_reg <= wdata[0];
            if (is_store && addr == ADDR_GAIN)   gain_reg       <= wdata[SHIFT_WIDTH-1:0];
            if (st_cnt_rst) begin
                cycle_count_reg <= '0;
                instr_count_reg <= '0;
            end else begin
                cycle_count_reg <= cycle_count_reg + 32'd1;
                if (en && sel != SEL_NOP) instr_count_reg <= instr_count_reg + 32'd1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_shift
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    shift_reg[gi] <= '0;
                else if (is_store && shift_hit && int'(shift_sel) == gi)
                    shift_reg[gi] <= wdata[SHIFT_WIDTH-1:0];
            end
        end
    endgenerate

    assign sine_shift     = shift_reg[0];
    assign square_shift   = shift_reg[1];
    assign triangle_shift = shift_reg[2];
    assign sawtooth_shift = shift_reg[3];
    assign global_gain    = gain_reg;
    assign dac_source     = dac_source_reg;

    // ---------------- per-voice registers ----------------
    logic [NUM_VOICES-1:0] flag_vec;

    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            logic                 hit;
            logic                 clear_flag;
            logic [FCW_WIDTH-1:0] fcw_reg;
            logic                 start_reg, release_reg, reset_reg, flag_reg;

            assign hit        = voice_valid && (int'(voice_idx) == gi);
            assign clear_flag = (hit && is_load && voice_off == OFF_FINISH) || st_glob_rst;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    fcw_reg     <= '0;
                    start_reg   <= 1'b0;
                    release_reg <= 1'b0;
                    reset_reg   <= 1'b0;
                    flag_reg    <= 1'b0;
                end else begin
                    if (hit && is_store && voice_off == OFF_FCW)
                        fcw_reg <= wdata[FCW_WIDTH-1:0];
                    start_reg   <= hit && is_store && (voice_off == OFF_START);
                    release_reg <= hit && is_store && (voice_off == OFF_RELEASE);
                    reset_reg   <= st_glob_rst || (hit && is_store && (voice_off == OFF_RESET));
                    // A finished pulse beats a coinciding clear so no event is lost.
                    if (note_finished[gi])
                        flag_reg <= 1'b1;
                    else if (clear_flag)
                        flag_reg <= 1'b0;
                end
            end

            assign fcw[gi*FCW_WIDTH +: FCW_WIDTH] = fcw_reg;
            assign note_start[gi]   = start_reg;
            assign note_release[gi] = release_reg;
            assign note_reset[gi]   = reset_reg;
            assign flag_vec[gi]     = flag_reg;
        end
    endgenerate

    // ---------------- PWM duty handshake ----------------
    pwm_state_t              pwm_state_reg;
    logic                    tx_req_reg;
    logic [DUTY_WIDTH-1:0]   duty_reg, pending_duty_reg;
    logic                    pending_valid_reg;
    logic                    ack_meta_reg, ack_sync_reg;
    logic                    pwm_busy;

    assign pwm_busy = (pwm_state_reg != PWM_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_state_reg     <= PWM_IDLE;
            tx_req_reg        <= 1'b0;
            duty_reg          <= '0;
            pending_duty_reg  <= '0;
            pending_valid_reg <= 1'b0;
            ack_meta_reg      <= 1'b0;
            ack_sync_reg      <= 1'b0;
        end else begin
            ack_meta_reg <= tx_ack;
            ack_sync_reg <= ack_meta_reg;
            case (pwm_state_reg)
                PWM_IDLE: begin
                    // A fresh store is newer than anything pending, so it wins.
                    if (st_duty || pending_valid_reg) begin
                        duty_reg          <= st_duty ? wdata[DUTY_WIDTH-1:0] : pending_duty_reg;
                        pending_valid_reg <= 1'b0;
                        tx_req_reg        <= 1'b1;
                        pwm_state_reg     <= PWM_REQ;
                    end
                end
                PWM_REQ: begin
                    if (ack_sync_reg) begin
                        tx_req_reg    <= 1'b0;
                        pwm_state_reg <= PWM_DROP;
                    end
                end
                PWM_DROP: begin
                    if (!ack_sync_reg) pwm_state_reg <= PWM_IDLE;
                end
                default: begin
                    tx_req_reg    <= 1'b0;
                    pwm_state_reg <= PWM_IDLE;
                end
            endcase
            // Stores during a handshake park in a one-deep slot; the last one wins.
            if (st_duty && pwm_busy) begin
                pending_valid_reg <= 1'b1;
                pending_duty_reg  <= wdata[DUTY_WIDTH-1:0];
            end
        end
    end

    assign tx_req     = tx_req_reg;
    assign duty_cycle = duty_reg;

    // ---------------- load path ----------------
    logic [31:0] read_value;
    logic [31:0] rdata_reg;

    always_comb begin
        read_value = '0;
        case (addr)
            ADDR_CYCLE:  read_value = cycle_count_reg;
            ADDR_INSTR:  read_value = instr_count_reg;
            ADDR_STATUS: read_value = {30'd0, pending_valid_reg, pwm_busy};
            ADDR_DACSRC: read_value = {31'd0, dac_source_reg};
            ADDR_GAIN:   read_value = 32'(gain_reg);
            default:     ;
        endcase
        if (shift_hit) read_value = 32'(shift_reg[shift_sel]);
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (voice_win && int'(voice_idx) == i) begin
                if (voice_off == OFF_FCW)
                    read_value = 32'(fcw[i*FCW_WIDTH +: FCW_WIDTH]);
                else if (voice_off == OFF_FINISH)
                    read_value = {31'd0, flag_vec[i] | note_finished[i]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rdata_reg <= '0;
        else if (is_load)
            rdata_reg <= read_value;
    end

    assign rdata = rdata_reg;

endmodule

// File: tb/tb_mmap_synth_regs.sv
`timescale 1ns/1ps
module tb_mmap_synth_regs;
    localparam int NV = 4;
    localparam int FW = 24;
    localparam int SW = 5;
    localparam int DW = 12;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_STORE = 3'd2;
    localparam logic [2:0] S_NOP   = 3'd6;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [15:0]       addr;
    logic [2:0]        sel;
    logic [31:0]       wdata, rdata;
    logic [NV*FW-1:0]  fcw;
    logic [NV-1:0]     note_start, note_release, note_reset, note_finished;
    logic [SW-1:0]     sine_shift, square_shift, triangle_shift, sawtooth_shift, global_gain;
    logic              dac_source;
    logic [DW-1:0]     duty_cycle;
    logic              tx_req, tx_ack;

    int n_checks = 0;
    int n_errors = 0;

    mmap_synth_regs #(.NUM_VOICES(NV), .FCW_WIDTH(FW), .SHIFT_WIDTH(SW), .DUTY_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .en(en), .addr(addr), .sel(sel), .wdata(wdata), .rdata(rdata),
        .fcw(fcw), .note_start(note_start), .note_release(note_release), .note_reset(note_reset),
        .note_finished(note_finished), .sine_shift(sine_shift), .square_shift(square_shift),
        .triangle_shift(triangle_shift), .sawtooth_shift(sawtooth_shift), .global_gain(global_gain),
        .dac_source(dac_source), .duty_cycle(duty_cycle), .tx_req(tx_req), .tx_ack(tx_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    localparam int NVEC = 28;
    vec_t vecs [NVEC];

    // Reference model of the register file.
    logic [FW-1:0] m_fcw   [NV];
    logic [SW-1:0] m_shift [4];
    logic [SW-1:0] m_gain;
    logic          m_dac;
    logic [NV-1:0] m_flag;
    logic [31:0]   m_rdata;
    logic [15:0]   glist [9];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        n_checks++;
        if (val < lo || val > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    // One bus cycle; returns 1ns after the edge with the bus idle again.
    task automatic access(input logic e, input logic [2:0] s, input logic [15:0] a,
                          input logic [31:0] d, input logic [NV-1:0] fin);
        en = e; sel = s; addr = a; wdata = d; note_finished = fin;
        @(posedge clk); #1;
        en = 1'b0; sel = 3'd0; addr = 16'd0; wdata = 32'd0; note_finished = '0;
    endtask

    task automatic do_load(input logic [15:0] a, output logic [31:0] v);
        access(1'b1, S_LOAD, a, 32'd0, '0);
        v = rdata;
    endtask

    task automatic do_store(input logic [15:0] a, input logic [31:0] d);
        access(1'b1, S_STORE, a, d, '0);
    endtask

    task automatic idle();
        access(1'b0, 3'd0, 16'd0, 32'd0, '0);
    endtask

    task automatic rand_op(input int n);
        int kind, ai, v, off;
        logic [15:0] a;
        logic [31:0] d;
        logic [NV-1:0] fin, x_start, x_rel, x_rst;
        logic e;
        logic [2:0] s;
        logic [NV*FW-1:0] x_fcw;
        kind = $urandom_range(0, 9);
        if ($urandom_range(0, 1) == 1) a = glist[$urandom_range(0, 8)];
        else a = 16'h1000 + 16'($urandom_range(0, 7) * 32 + $urandom_range(0, 5) * 4);
        d   = $urandom;
        fin = ($urandom_range(0, 3) == 0) ? NV'($urandom) : '0;
        e = 1'b1;
        if (kind <= 3) s = S_LOAD;
        else if (kind <= 7) s = S_STORE;
        else if (kind == 8) s = S_NOP;
        else begin
            e = 1'b0;
            s = ($urandom_range(0, 1) == 1) ? S_LOAD : S_STORE;
        end
        if (e && s == S_STORE && a == 16'h0100) fin = '0;
        x_start = '0; x_rel = '0; x_rst = '0;
        ai  = int'(a);
        v   = (ai - 'h1000) / 32;
        off = ai % 32;
        m_flag = m_flag | fin;
        if (e && s == S_LOAD) begin
            m_rdata = 32'd0;
            if (ai == 'h44) m_rdata = 32'(m_dac);
            else if (ai == 'h104) m_rdata = 32'(m_gain);
            else if (ai >= 'h200 && ai <= 'h20C) m_rdata = 32'(m_shift[(ai - 'h200) / 4]);
            else if (ai >= 'h1000 && ai < 'h1100 && v < NV) begin
                if (off == 0) m_rdata = 32'(m_fcw[v]);
                else if (off == 12) begin
                    m_rdata = 32'(m_flag[v]);
                    m_flag[v] = fin[v];
                end
            end
        end else if (e && s == S_STORE) begin
            if (ai == 'h44) m_dac = d[0];
            else if (ai == 'h104) m_gain = d[SW-1:0];
            else if (ai >= 'h200 && ai <= 'h20C) m_shift[(ai - 'h200) / 4] = d[SW-1:0];
            else if (ai == 'h100) begin
                x_rst = '1;
                m_flag = '0;
            end else if (ai >= 'h1000 && ai < 'h1100 && v < NV) begin
                if (off == 0) m_fcw[v] = d[FW-1:0];
                else if (off == 4) x_start[v] = 1'b1;
                else if (off == 8) x_rel[v] = 1'b1;
                else if (off == 16) x_rst[v] = 1'b1;
            end
        end
        access(e, s, a, d, fin);
        for (int i = 0; i < NV; i++) x_fcw[i*FW +: FW] = m_fcw[i];
        check($sformatf("rand%0d_rdata a=%h", n, a), rdata, m_rdata);
        check($sformatf("rand%0d_pulses", n), {note_start, note_release, note_reset}, {x_start, x_rel, x_rst});
        check($sformatf("rand%0d_fcw", n), fcw, x_fcw);
        check($sformatf("rand%0d_globals", n),
              {dac_source, global_gain, sawtooth_shift, triangle_shift, square_shift, sine_shift},
              {m_dac, m_gain, m_shift[3], m_shift[2], m_shift[1], m_shift[0]});
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] v0, v1;
        int k;
        vecs[0]  = '{S_LOAD,  16'h0040, 32'h0,        32'h0};
        vecs[1]  = '{S_LOAD,  16'h0044, 32'h0,        32'h0};
        vecs[2]  = '{S_LOAD,  16'h0104, 32'h0,        32'h0};
        vecs[3]  = '{S_LOAD,  16'h0200, 32'h0,        32'h0};
        vecs[4]  = '{S_LOAD,  16'h0204, 32'h0,        32'h0};
        vecs[5]  = '{S_LOAD,  16'h0208, 32'h0,        32'h0};
        vecs[6]  = '{S_LOAD,  16'h020C, 32'h0,        32'h0};
        vecs[7]  = '{S_LOAD,  16'h1040, 32'h0,        32'h0};
        vecs[8]  = '{S_LOAD,  16'h106C, 32'h0,        32'h0};
        vecs[9]  = '{S_LOAD,  16'h1000, 32'h0,        32'h0};
        vecs[10] = '{S_STORE, 16'h1040, 32'h00123456, 32'h0};
        vecs[11] = '{S_LOAD,  16'h1040, 32'h0,        32'h00123456};
        vecs[12] = '{S_STORE, 16'h1060, 32'hFFABCDEF, 32'h0};
        vecs[13] = '{S_LOAD,  16'h1060, 32'h0,        32'h00ABCDEF};
        vecs[14] = '{S_STORE, 16'h0104, 32'hFFFFFFE3, 32'h0};
        vecs[15] = '{S_LOAD,  16'h0104, 32'h0,        32'h00000003};
        vecs[16] = '{S_STORE, 16'h0208, 32'h0000001A, 32'h0};
        vecs[17] = '{S_LOAD,  16'h0208, 32'h0,        32'h0000001A};
        vecs[18] = '{S_STORE, 16'h10A0, 32'h00000777, 32'h0};
        vecs[19] = '{S_LOAD,  16'h10A0, 32'h0,        32'h0};
        vecs[20] = '{S_STORE, 16'h0044, 32'hFFFFFFFE, 32'h0};
        vecs[21] = '{S_LOAD,  16'h0044, 32'h0,        32'h0};
        vecs[22] = '{S_STORE, 16'h0044, 32'h00000001, 32'h0};
        vecs[23] = '{S_LOAD,  16'h0044, 32'h0,        32'h1};
        vecs[24] = '{S_STORE, 16'h0300, 32'h00005555, 32'h0};
        vecs[25] = '{S_LOAD,  16'h0300, 32'h0,        32'h0};
        vecs[26] = '{S_LOAD,  16'h1040, 32'h0,        32'h00123456};
        vecs[27] = '{S_LOAD,  16'h0200, 32'h0,        32'h0};
        glist = '{16'h0044, 16'h0104, 16'h0200, 16'h0204, 16'h0208, 16'h020C, 16'h0100, 16'h0030, 16'h0400};

        rst = 1'b0; en = 1'b0; sel = 3'd0; addr = 16'd0; wdata = 32'd0;
        note_finished = '0; tx_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata", rdata, 32'd0);
        check("reset_fcw", fcw, '0);
        check("reset_pulses", {note_start, note_release, note_reset}, 12'd0);
        check("reset_shifts", {sine_shift, square_shift, triangle_shift, sawtooth_shift, global_gain}, 25'd0);
        check("reset_dac_duty_req", {dac_source, duty_cycle, tx_req}, 14'd0);
        rst = 1'b1;

        // Table-driven register accesses.
        for (int i = 0; i < NVEC; i++) begin
            access(1'b1, vecs[i].sel, vecs[i].addr, vecs[i].wdata, '0);
            if (vecs[i].sel == S_LOAD) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp);
        end
        check("fcw_voice2_out", fcw[71:48], 24'h123456);
        check("fcw_voice3_out", fcw[95:72], 24'hABCDEF);
        check("gain_out", global_gain, 5'h03);
        check("triangle_out", triangle_shift, 5'h1A);
        check("dac_out", dac_source, 1'b1);
        do_load(16'h1040, v0);
        do_store(16'h0300, 32'h1);
        idle();
        check("rdata_hold", rdata, 32'h00123456);

        // Note pulses.
        do_store(16'h1024, 32'hDEADBEEF);
        check("start_v1_pulse", {note_start, note_release, note_reset}, {4'b0010, 4'b0000, 4'b0000});
        idle();
        check("start_v1_gone", note_start, 4'b0000);
        do_store(16'h1008, 32'h0);
        check("release_v0_pulse", {note_start, note_release, note_reset}, {4'b0000, 4'b0001, 4'b0000});
        do_store(16'h1070, 32'h0);
        check("reset_v3_pulse", {note_start, note_release, note_reset}, {4'b0000, 4'b0000, 4'b1000});

        // Global synth reset clears flags, leaves FCW and shifts.
        access(1'b0, 3'd0, 16'd0, 32'd0, 4'b0101);
        do_store(16'h0100, 32'h0);
        check("glob_reset_pulse", note_reset, 4'b1111);
        idle();
        check("glob_reset_gone", note_reset, 4'b0000);
        do_load(16'h100C, v0);
        check("glob_flag_v0", v0, 32'd0);
        do_load(16'h104C, v0);
        check("glob_flag_v2", v0, 32'd0);
        check("glob_keeps_fcw", fcw[71:48], 24'h123456);
        check("glob_keeps_shift", triangle_shift, 5'h1A);

        // Sticky finished flag, clear-on-read, set beats clear.
        access(1'b0, 3'd0, 16'd0, 32'd0, 4'b1000);
        do_load(16'h106C, v0);
        check("fin_first_read", v0, 32'd1);
        do_load(16'h106C, v0);
        check("fin_second_read", v0, 32'd0);
        access(1'b1, S_LOAD, 16'h106C, 32'd0, 4'b1000);
        check("fin_coincide_read", rdata, 32'd1);
        do_load(16'h106C, v0);
        check("fin_after_coincide", v0, 32'd1);
        do_load(16'h106C, v0);
        check("fin_cleared", v0, 32'd0);

        // Counters. Between two loads 11 cycles apart the cycle count grows by 11;
        // the instruction count grows by the first load plus the 6 non-nop cycles.
        do_load(16'h0014, v0);
        for (int j = 0; j < 10; j++) access(1'b1, (j % 2 == 1 && j < 9) ? S_NOP : 3'd3, 16'h0, 32'h0, '0);
        do_load(16'h0014, v1);
        check("instr_delta", v1 - v0, 32'd7);
        do_load(16'h0010, v0);
        for (int j = 0; j < 10; j++) access(1'b1, (j % 2 == 1 && j < 9) ? S_NOP : 3'd3, 16'h0, 32'h0, '0);
        do_load(16'h0010, v1);
        check("cycle_delta", v1 - v0, 32'd11);
        do_load(16'h0014, v0);
        access(1'b0, S_LOAD, 16'h0014, 32'h0, '0);
        access(1'b0, S_STORE, 16'h0018, 32'h0, '0);
        repeat (3) idle();
        do_load(16'h0014, v1);
        check("instr_en_low", v1 - v0, 32'd1);
        do_store(16'h0018, 32'h0);
        do_load(16'h0010, v0);
        check_range("cycle_after_clear", int'(v0), 0, 2);
        do_load(16'h0014, v0);
        check_range("instr_after_clear", int'(v0), 0, 2);

        // PWM handshake.
        check("pwm_idle_req", tx_req, 1'b0);
        do_store(16'h0034, 32'hFFFF_F800);
        check("pwm_req_rise", tx_req, 1'b1);
        check("pwm_duty_800", duty_cycle, 12'h800);
        do_load(16'h0040, v0);
        check("pwm_status_busy", v0, 32'd1);
        tx_ack = 1'b1;
        k = 0;
        while (tx_req === 1'b1 && k < 10) begin @(posedge clk); #1; k++; end
        check_range("pwm_ack_to_drop_edges", k, 2, 4);
        do_store(16'h0034, 32'h100);
        do_store(16'h0034, 32'h200);
        do_load(16'h0040, v0);
        check("pwm_status_pending", v0, 32'd3);
        check("pwm_duty_held", duty_cycle, 12'h800);
        check("pwm_req_low_drop", tx_req, 1'b0);
        tx_ack = 1'b0;
        k = 0;
        while (tx_req !== 1'b1 && k < 12) begin @(posedge clk); #1; k++; end
        check_range("pwm_reassert_edges", k, 3, 5);
        check("pwm_duty_200", duty_cycle, 12'h200);
        do_load(16'h0040, v0);
        check("pwm_status_consumed", v0, 32'd1);
        rst = 1'b0;
        #1;
        check("pwm_async_reset", {tx_req, duty_cycle}, 13'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        do_load(16'h0040, v0);
        check("pwm_status_after_reset", v0, 32'd0);
        check("fcw_after_reset", fcw, '0);

        // Randomised accesses against the model (everything is reset now).
        for (int i = 0; i < NV; i++) m_fcw[i] = '0;
        for (int i = 0; i < 4; i++) m_shift[i] = '0;
        m_gain = '0; m_dac = 1'b0; m_flag = '0; m_rdata = 32'd0;
        for (int n = 0; n < 400; n++) rand_op(n);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mmap_synth_regs.md
# mmap_synth_regs

Parametrised memory-mapped control block for the multi-voice synthesizer. It decodes CPU loads and stores in the I/O window and holds the global and per-voice synth registers. It generates one-cycle note control pulses, latches sticky per-voice note-finished flags, and runs the cycle and instruction counters. It also drives the PWM duty-cycle request/acknowledge handshake autonomously, so software only writes a duty value. It sits between the CPU memory stage and the signal chain / pwm_controller.

## Interface
- NUM_VOICES, 4, number of voices (1..8)
- FCW_WIDTH, 24, frequency control word width per voice
- SHIFT_WIDTH, 5, width of NCO and global-gain shift fields
- DUTY_WIDTH, 12, PWM duty-cycle width
- clk  in  1  the single clock; all state is on its rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  access enable; without it, no decode, store or read-clear happens
- addr  in  16  low I/O address (word aligned)
- sel  in  3  1=LOAD, 2=STORE, 6=injected nop, others ignored
- wdata  in  32  store data
- rdata  out  32  registered load data
- fcw  out  NUM_VOICES*FCW_WIDTH  per-voice FCW, voice v at bits [v*FCW_WIDTH +: FCW_WIDTH]
- note_start, note_release, note_reset  out  NUM_VOICES each  one-cycle pulses per voice
- note_finished  in  NUM_VOICES  one-cycle finished pulses from the voices
- sine_shift, square_shift, triangle_shift, sawtooth_shift, global_gain  out  SHIFT_WIDTH each
- dac_source  out  1  0=CPU duty, 1=synth
- duty_cycle  out  DUTY_WIDTH  duty value presented to pwm_controller
- tx_req  out  1  handshake request
- tx_ack  in  1  handshake acknowledge (foreign domain, synchronised internally)

## Operation
- Address map:
  - 0x0010 cycle count (R)
  - 0x0014 instruction count (R)
  - 0x0018 counter reset (W)
  - 0x0034 PWM duty (W)
  - 0x0040 PWM status (R: bit0 busy, bit1 pending)
  - 0x0044 dac_source (R/W bit0)
  - 0x0100 global synth reset (W)
  - 0x0104 global_gain (R/W)
  - 0x0200 / 0x0204 / 0x0208 / 0x020C NCO sine / square / triangle / sawtooth shift (R/W)
- Voice window: base 0x1000 + 0x20*v.
  - +0x0 FCW (R/W)
  - +0x4 start (W)
  - +0x8 release (W)
  - +0xC finished (R, clear-on-read)
  - +0x10 voice reset (W)
- Voice index v >= NUM_VOICES: stores ignored, loads return 0.
- Register stores use the low bits of wdata; unused high bits are ignored. Loads zero-extend.
- Unmapped load returns 0. Unmapped store has no effect.
- Pulses: a store to start, release or reset for voice v raises that bit for exactly one cycle. wdata is ignored.
- Global synth reset store:
  - pulses all note_reset bits for one cycle
  - clears all finished flags
  - leaves FCWs and shifts unchanged
- Finished flags: set by a note_finished pulse, cleared by a load of that voice's finished register. If set and clear coincide, set wins: the load returns 1 and the flag stays 1.
- Counters:
  - cycle count increments every cycle
  - instruction count increments when en=1 and sel!=6
  - a store to 0x0018 zeroes both; they resume counting the following cycle
  - both wrap at 2^32
- PWM handshake FSM (tx_ack passes a 2-flop synchroniser first):
  - IDLE: tx_req=0. A duty store, or an already pending value, loads duty_cycle and moves to REQ.
  - REQ: tx_req=1. Synchronised ack=1 moves to DROP.
  - DROP: tx_req=0. Synchronised ack=0 moves to IDLE.
  - busy = state != IDLE.
  - A duty store while busy writes a one-deep pending register; later stores overwrite it, so only the last value is kept. Pending is consumed on the IDLE entry cycle.

## Timing
- Reset (rst=0), asynchronous:
  - all outputs 0, rdata 0
  - FSM in IDLE, pending cleared, flags cleared, counters 0
- Reset asserted mid-handshake drops tx_req immediately and discards pending.
- Store effect: register outputs update and pulses assert in the cycle after the store edge.
- Load latency: rdata is valid one cycle after the LOAD cycle and holds until the next load.
- Read-clear takes effect at the same edge that registers rdata.
- tx_req rises 1 cycle after a duty store accepted in IDLE.
- tx_ack to state change costs 2 cycles of synchroniser latency.
- A pending value re-raises tx_req 1 cycle after the FSM returns to IDLE.

## Test plan
- Reset, then load each readable address -> all return 0. Store FCW 0x123456 to voice 2, then load 0x1040 -> 0x00123456; fcw[71:48]=0x123456.
- Store to 0x1024 (voice 1 start) -> note_start=4'b0010 for exactly one cycle. Store to 0x0100 -> note_reset=4'b1111 for one cycle and all flags clear.
- Pulse note_finished[3], then load 0x106C twice -> first load returns 1, second returns 0. With the pulse coinciding with the load -> that load returns 1 and the next also returns 1.
- Store duty 0x800 -> tx_req=1. Raise tx_ack -> tx_req=0 after 2 cycles. Store 0x100 then 0x200 while busy -> status=3. After ack low, duty_cycle=0x200 and tx_req reasserts.
- Assert rst for one cycle in REQ state -> tx_req=0 immediately, status=0, duty_cycle=0.
- Run 10 cycles with sel=6 on 4 of them -> cycle count advanced by 10, instruction count by 6. Store to 0x0018 -> next load of 0x0010 returns a small value (<=2).
